// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl: iterative rotation-mode CORDIC sequencer with external arctangent ROM
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   request pulse, sampled only while idle
//   x_in      in   initial x (WIDTH, two's complement)
//   y_in      in   initial y
//   z_in      in   initial angle
//   atan_idx  out  ROM address, always the current iteration index
//   atan_val  in   combinational ROM data for atan_idx, used in UPDATE
//   busy      out  high whenever the sequencer is not idle
//   done      out  one-cycle completion pulse
//   x_out     out  final x, registered, held until the next completed operation
//   y_out     out  final y
//   z_out     out  final z
module cordic_iter_ctrl #(
   parameter int WIDTH = 17,
   parameter int ITER  = 16,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] y_in,
   input  logic [WIDTH-1:0] z_in,
   output logic [IDX_W-1:0] atan_idx,
   input  logic [WIDTH-1:0] atan_val,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] x_out,
   output logic [WIDTH-1:0] y_out,
   output logic [WIDTH-1:0] z_out
);
   typedef enum logic [1:0] {IDLE, SHIFT, UPDATE, DONE} state_t;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(ITER - 1);
   state_t state, state_nxt;
   logic [WIDTH-1:0] x, y, z, xs, ys;
   logic [WIDTH-1:0] x_nxt, y_nxt, z_nxt, xs_nxt, ys_nxt;
   logic [WIDTH-1:0] xo_nxt, yo_nxt, zo_nxt;
   logic [WIDTH-1:0] x_upd, y_upd, z_upd;
   logic [IDX_W-1:0] i, i_nxt, sh_cnt, sh_nxt;
   logic             neg;
   always_comb begin
      state_nxt = state;
      x_nxt     = x;
      y_nxt     = y;
      z_nxt     = z;
      xs_nxt    = xs;
      ys_nxt    = ys;
      i_nxt     = i;
      sh_nxt    = sh_cnt;
      xo_nxt    = x_out;
      yo_nxt    = y_out;
      zo_nxt    = z_out;
      // rotation direction follows the sign of the residual angle
      neg       = z[WIDTH-1];
      x_upd     = neg ? x + ys : x - ys;
      y_upd     = neg ? y - xs : y + xs;
      z_upd     = neg ? z + atan_val : z - atan_val;
      case (state)
         IDLE: if (start) begin
            x_nxt     = x_in;
            y_nxt     = y_in;
            z_nxt     = z_in;
            xs_nxt    = x_in;
            ys_nxt    = y_in;
            i_nxt     = '0;
            sh_nxt    = '0;
            state_nxt = UPDATE;
         end
         SHIFT: begin
            xs_nxt = {xs[WIDTH-1], xs[WIDTH-1:1]};
            ys_nxt = {ys[WIDTH-1], ys[WIDTH-1:1]};
            sh_nxt = sh_cnt + IDX_W'(1);
            // leave as soon as xs/ys hold the shift-by-i terms
            if (sh_nxt == i) state_nxt = UPDATE;
         end
         UPDATE: begin
            x_nxt = x_upd;
            y_nxt = y_upd;
            z_nxt = z_upd;
            if (i == LAST) begin
               xo_nxt    = x_upd;
               yo_nxt    = y_upd;
               zo_nxt    = z_upd;
               state_nxt = DONE;
            end else begin
               i_nxt     = i + IDX_W'(1);
               xs_nxt    = x_upd;
               ys_nxt    = y_upd;
               sh_nxt    = '0;
               state_nxt = SHIFT;
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         x      <= '0;
         y      <= '0;
         z      <= '0;
         xs     <= '0;
         ys     <= '0;
         i      <= '0;
         sh_cnt <= '0;
         x_out  <= '0;
         y_out  <= '0;
         z_out  <= '0;
      end else begin
         state  <= state_nxt;
         x      <= x_nxt;
         y      <= y_nxt;
         z      <= z_nxt;
         xs     <= xs_nxt;
         ys     <= ys_nxt;
         i      <= i_nxt;
         sh_cnt <= sh_nxt;
         x_out  <= xo_nxt;
         y_out  <= yo_nxt;
         z_out  <= zo_nxt;
      end
   end
   assign busy     = state != IDLE;
   assign done     = state == DONE;
   assign atan_idx = i;
endmodule

// File: doc/cordic_iter_ctrl.md
Name: cordic_iter_ctrl

Overview:
- Iterative rotation-mode CORDIC sequencer for the 17-bit datapath.
- Owns the x/y/z working registers, the iteration counter and the shift counter.
- Builds the shift-by-i term by applying the 1-bit arithmetic right shift i times, one shift per clock, then performs one add/sub update per iteration.
- Arctangent constants come from an external ROM addressed by this block; the block sits between the host start/done handshake and that ROM.

Parameters:
- WIDTH, 17: datapath width, two's complement, for x, y and z.
- ITER, 16: number of CORDIC iterations; legal range 1..2^IDX_W.
- IDX_W, 4: width of the iteration index and the ROM address.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- x_in  in  WIDTH  initial x.
- y_in  in  WIDTH  initial y.
- z_in  in  WIDTH  initial angle.
- atan_idx  out  IDX_W  ROM address, equal to the current iteration i.
- atan_val  in  WIDTH  combinational ROM data for atan_idx; sampled in UPDATE.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse (state == DONE).
- x_out  out  WIDTH  final x, registered.
- y_out  out  WIDTH  final y, registered.
- z_out  out  WIDTH  final z, registered.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - x, y, z, xs, ys, i and sh_cnt cleared.
  - busy=0, done=0, atan_idx=0, x_out/y_out/z_out=0.
  - Reset asserted mid-operation aborts immediately; no partial result is kept.
- States: IDLE, SHIFT, UPDATE, DONE.
- IDLE, start=1:
  - Latch x=x_in, y=y_in, z=z_in, xs=x_in, ys=y_in.
  - i=0, sh_cnt=0; next state UPDATE (iteration 0 needs no shift).
- SHIFT:
  - Each cycle: xs={xs[MSB],xs[MSB:1]}, ys likewise (sign-replicating shift by 1).
  - sh_cnt++.
  - Move to UPDATE on the cycle that makes sh_cnt==i.
- UPDATE:
  - d is taken from z[MSB].
  - z >= 0: x<=x-ys, y<=y+xs, z<=z-atan_val.
  - z < 0: x<=x+ys, y<=y-xs, z<=z+atan_val.
  - All arithmetic is modulo 2^WIDTH: wrap, no saturation, no growth bits.
  - If i==ITER-1: copy the new x/y/z to x_out/y_out/z_out; next state DONE.
  - Else: i++, xs<=new x, ys<=new y, sh_cnt=0; next state SHIFT.
- DONE: done=1 for exactly one cycle, then IDLE. The outputs hold until the next completed operation.
- Latency: ITER*(ITER+1)/2 clocks from the start-sampling edge to the edge that enters DONE. That is 136 for ITER=16, so done is high in cycle 137.
- start while busy (including the DONE cycle) is ignored; no queueing.
- atan_idx=i in every state; it is stable throughout UPDATE.
- x_in/y_in/z_in are don't-care except at the start-sampling edge.

Test Plan:
- Reset mid-run: assert rst_n=0 at cycle 40 of an ITER=16 run -> busy, done, x_out/y_out/z_out and atan_idx all 0 at once; a new start is then accepted normally.
- ITER=2, x_in=0x04000, y_in=0, z_in=0x00100, ROM[0]=0x00C90, ROM[1]=0x0076B -> after iter 0: x=0x04000, y=0x04000, z=0x1F470; done in cycle 4; final x_out=0x06000, y_out=0x02000, z_out=0x1FBDB.
- Sign-extending shift, ITER=2, x_in=0x10000, y=z=0, ROM all 0 -> xs=ys=0x18000 in iter 1; x_out=0x18000, y_out=0x08000, z_out=0.
- Wrap, ITER=1, x_in=y_in=0x0FFFF, z_in=0, ROM[0]=0 -> x_out=0x00000, y_out=0x1FFFE; done 2 cycles after start.
- ITER=16 timing -> atan_idx steps 0..15; busy high for 137 cycles; done pulses exactly once in cycle 137; start pulses at cycles 5 and 137 are ignored.
- Back-to-back: assert start in the first IDLE cycle after done with new operands -> accepted; the previous outputs hold until the second run's UPDATE i=ITER-1.
